// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron layer controller.
package nn_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_DRAIN,
      S_BIAS,
      S_ACT,
      S_OUT
   } state_e;

   function automatic logic signed [63:0] sat_to(
      input logic signed [63:0] v,
      input int                 w
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)      sat_to = hi;
      else if (v < lo) sat_to = lo;
      else             sat_to = v;
   endfunction

endpackage

// File: rtl/nn_mac.sv
// Signed multiply-accumulate with synchronous clear; wraps modulo 2^ACC_W.
module nn_mac #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc_q;
   logic signed [ACC_W-1:0]    acc_d;

   assign prod = a * b;

   always_comb begin
      acc_d = acc_q;
      if (clear)   acc_d = '0;
      else if (en) acc_d = acc_q + ACC_W'(prod);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Sequences one dense layer: MAC over inputs, bias, activation, output handshake.
module neuron_layer_ctrl
   import nn_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int N_IN     = 4,
   parameter int N_NEURON = 3,
   parameter int ACC_W    = 2*DATA_W+8,
   parameter int OUT_W    = DATA_W+8,
   localparam int XW = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int WW = (N_IN*N_NEURON > 1) ? $clog2(N_IN*N_NEURON) : 1,
   localparam int NW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     relu_en,
   output logic [XW-1:0]            x_addr,
   output logic [WW-1:0]            w_addr,
   output logic                     rd_en,
   input  logic signed [DATA_W-1:0] x_data,
   input  logic signed [DATA_W-1:0] w_data,
   output logic [NW-1:0]            b_addr,
   input  logic signed [DATA_W-1:0] bias_data,
   output logic signed [OUT_W-1:0]  out_data,
   output logic [NW-1:0]            out_idx,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done
);

   state_e                  state_q, state_d;
   logic [XW-1:0]           in_q, in_d;
   logic [NW-1:0]           neu_q, neu_d;
   logic                    relu_q, relu_d;
   logic                    rv_q;
   logic signed [OUT_W-1:0] out_q, out_d;
   logic [NW-1:0]           oidx_q, oidx_d;
   logic                    ov_q, ov_d;
   logic                    done_q, done_d;

   logic                    clr;
   logic                    bias_add;
   logic                    mac_en;
   logic signed [DATA_W-1:0] mac_a;
   logic signed [DATA_W-1:0] mac_b;
   logic signed [ACC_W-1:0]  acc;
   logic signed [63:0]       acc_x;
   logic signed [63:0]       act_v;
   logic signed [63:0]       sat_v;
   int                       w_lin;

   // Bias rides through the multiplier as bias*1.
   assign mac_en = rv_q | bias_add;
   assign mac_a  = bias_add ? bias_data : x_data;
   assign mac_b  = bias_add ? DATA_W'(1) : w_data;

   nn_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clr),
      .en    (mac_en),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (acc)
   );

   assign acc_x = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
   assign act_v = (relu_q && acc_x < 0) ? 64'sd0 : acc_x;
   assign sat_v = sat_to(act_v, OUT_W);

   always_comb begin
      w_lin  = int'(neu_q) * N_IN + int'(in_q);
      w_addr = WW'(w_lin);
   end

   always_comb begin
      state_d  = state_q;
      in_d     = in_q;
      neu_d    = neu_q;
      relu_d   = relu_q;
      out_d    = out_q;
      oidx_d   = oidx_q;
      ov_d     = ov_q;
      done_d   = 1'b0;
      clr      = 1'b0;
      bias_add = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               clr     = 1'b1;
               in_d    = '0;
               neu_d   = '0;
               relu_d  = relu_en;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            in_d = in_q + XW'(1);
            if (in_q == XW'(N_IN-1)) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_BIAS;
         S_BIAS: begin
            bias_add = 1'b1;
            state_d  = S_ACT;
         end
         S_ACT: begin
            out_d   = sat_v[OUT_W-1:0];
            oidx_d  = neu_q;
            ov_d    = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               ov_d = 1'b0;
               if (neu_q == NW'(N_NEURON-1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  neu_d   = neu_q + NW'(1);
                  in_d    = '0;
                  clr     = 1'b1;
                  state_d = S_MAC;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         in_q    <= '0;
         neu_q   <= '0;
         relu_q  <= 1'b0;
         rv_q    <= 1'b0;
         out_q   <= '0;
         oidx_q  <= '0;
         ov_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         in_q    <= in_d;
         neu_q   <= neu_d;
         relu_q  <= relu_d;
         rv_q    <= (state_q == S_MAC);
         out_q   <= out_d;
         oidx_q  <= oidx_d;
         ov_q    <= ov_d;
         done_q  <= done_d;
      end
   end

   assign rd_en     = (state_q == S_MAC);
   assign x_addr    = in_q;
   assign b_addr    = neu_q;
   assign out_data  = out_q;
   assign out_idx   = oidx_q;
   assign out_valid = ov_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Directed bench for neuron_layer_ctrl with an arithmetic reference model.
module tb_neuron_layer_ctrl;

   localparam int DW  = 8;
   localparam int NI  = 4;
   localparam int NN  = 3;
   localparam int AW  = 2*DW+8;
   localparam int OW  = 10;

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic                 relu_en;
   logic [1:0]           x_addr;
   logic [3:0]           w_addr;
   logic                 rd_en;
   logic signed [DW-1:0] x_data;
   logic signed [DW-1:0] w_data;
   logic [1:0]           b_addr;
   logic signed [DW-1:0] bias_data;
   logic signed [OW-1:0] out_data;
   logic [1:0]           out_idx;
   logic                 out_valid;
   logic                 out_ready;
   logic                 busy;
   logic                 done;

   logic signed [DW-1:0] x_mem [NI];
   logic signed [DW-1:0] w_mem [NI*NN];
   logic signed [DW-1:0] b_mem [NN];

   int checks;
   int errors;
   int hs_cnt;
   int exp_d [$];
   int exp_i [$];

   neuron_layer_ctrl #(
      .DATA_W   (DW),
      .N_IN     (NI),
      .N_NEURON (NN),
      .ACC_W    (AW),
      .OUT_W    (OW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .relu_en   (relu_en),
      .x_addr    (x_addr),
      .w_addr    (w_addr),
      .rd_en     (rd_en),
      .x_data    (x_data),
      .w_data    (w_data),
      .b_addr    (b_addr),
      .bias_data (bias_data),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) begin
         x_data <= x_mem[x_addr];
         w_data <= w_mem[w_addr];
      end
   end

   assign bias_data = b_mem[b_addr];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: dot product + bias, wrap to ACC_W, then activation/clamp.
   function automatic int model_out(input int n, input bit relu);
      longint s;
      longint m;
      s = 0;
      for (int i = 0; i < NI; i++)
         s += longint'(x_mem[i]) * longint'(w_mem[n*NI+i]);
      s += longint'(b_mem[n]);
      m = longint'(1) << AW;
      s = s % m;
      if (s < 0) s += m;
      if (s >= m/2) s -= m;
      if (relu && s < 0) s = 0;
      if (s > 511) s = 511;
      if (s < -512) s = -512;
      return int'(s);
   endfunction

   task automatic push_pass(input bit relu);
      for (int n = 0; n < NN; n++) begin
         exp_d.push_back(model_out(n, relu));
         exp_i.push_back(n);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_d.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got idx %0d data %0d expected none",
                     out_idx, out_data);
         end else begin
            check("model_out_data", int'(out_data), exp_d[0]);
            check("model_out_idx", int'(out_idx), exp_i[0]);
            if (out_ready) begin
               void'(exp_d.pop_front());
               void'(exp_i.pop_front());
               hs_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input bit relu);
      relu_en = relu;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      if (!out_valid) check("valid_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      check("done_seen", int'(done), 1);
   endtask

   task automatic load_basic();
      for (int i = 0; i < NI; i++) begin
         x_mem[i]        = DW'(i + 1);
         w_mem[i]        = 8'sd1;
         w_mem[NI+i]     = -8'sd1;
      end
      w_mem[8]  = 8'sd2;
      w_mem[9]  = 8'sd0;
      w_mem[10] = -8'sd1;
      w_mem[11] = 8'sd3;
      b_mem[0]  = 8'sd5;
      b_mem[1]  = 8'sd0;
      b_mem[2]  = -8'sd3;
   endtask

   task automatic load_fill(input logic signed [DW-1:0] wv);
      for (int i = 0; i < NI; i++) x_mem[i] = 8'sd127;
      for (int i = 0; i < NI*NN; i++) w_mem[i] = wv;
      for (int i = 0; i < NN; i++) b_mem[i] = 8'sd127;
   endtask

   initial begin
      int n;
      checks    = 0;
      errors    = 0;
      hs_cnt    = 0;
      rst_n     = 1'b0;
      start     = 1'b1;
      relu_en   = 1'b1;
      out_ready = 1'b1;
      load_basic();
      tick();
      tick();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_rd_en", int'(rd_en), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_data", int'(out_data), 0);
      check("rst_idx", int'(out_idx), 0);
      check("rst_xaddr", int'(x_addr), 0);
      check("rst_waddr", int'(w_addr), 0);
      check("rst_baddr", int'(b_addr), 0);
      start = 1'b0;
      rst_n = 1'b1;
      tick();

      check("model_pin_n0", model_out(0, 1'b1), 15);
      check("model_pin_n1_lin", model_out(1, 1'b0), -10);

      // relu pass, ready always high
      push_pass(1'b1);
      do_start(1'b1);
      check("busy_after_start", int'(busy), 1);
      check("rd_en_mac", int'(rd_en), 1);
      wait_valid(n);
      check("first_valid_latency", n, 7);
      check("n0_relu_lit", int'(out_data), 15);
      tick();
      wait_valid(n);
      check("n1_relu_lit", int'(out_data), 0);
      check("n1_relu_idx", int'(out_idx), 1);
      tick();
      wait_done();
      check("busy_in_done", int'(busy), 0);
      tick();
      check("done_one_cycle", int'(done), 0);

      // linear pass, stray start in MAC, stall on neuron1
      push_pass(1'b0);
      do_start(1'b0);
      wait_valid(n);
      check("n0_lin_lit", int'(out_data), 15);
      tick();
      start     = 1'b1;
      out_ready = 1'b0;
      tick();
      start     = 1'b0;
      wait_valid(n);
      check("n1_lin_lit", int'(out_data), -10);
      for (int k = 0; k < 5; k++) begin
         check("stall_valid", int'(out_valid), 1);
         check("stall_idx", int'(out_idx), 1);
         check("stall_data", int'(out_data), -10);
         check("stall_no_read", int'(rd_en), 0);
         check("stall_no_done", int'(done), 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      wait_valid(n);
      check("n2_lin_idx", int'(out_idx), 2);
      tick();
      wait_done();

      // positive saturation, then back-to-back pass in the done cycle
      load_fill(8'sd127);
      push_pass(1'b1);
      do_start(1'b1);
      wait_valid(n);
      check("sat_pos_lit", int'(out_data), 511);
      tick();
      wait_done();
      push_pass(1'b0);
      relu_en = 1'b0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      check("b2b_busy", int'(busy), 1);
      wait_done();

      // negative saturation
      load_fill(-8'sd128);
      push_pass(1'b0);
      do_start(1'b0);
      wait_valid(n);
      check("sat_neg_lit", int'(out_data), -512);
      tick();
      wait_done();

      // reset while in BIAS, then restart from neuron0
      load_basic();
      push_pass(1'b1);
      do_start(1'b1);
      repeat (5) tick();
      check("bias_rd_off", int'(rd_en), 0);
      check("bias_busy", int'(busy), 1);
      rst_n = 1'b0;
      exp_d.delete();
      exp_i.delete();
      tick();
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_rd", int'(rd_en), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_data", int'(out_data), 0);
      check("mid_rst_idx", int'(out_idx), 0);
      check("mid_rst_waddr", int'(w_addr), 0);
      rst_n = 1'b1;
      tick();
      push_pass(1'b1);
      do_start(1'b1);
      wait_valid(n);
      check("restart_idx", int'(out_idx), 0);
      check("restart_data", int'(out_data), 15);
      tick();
      wait_done();
      tick();

      check("queue_empty", exp_d.size(), 0);
      check("handshake_total", hs_cnt, 18);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_layer_ctrl.md
NEURON_LAYER_CTRL -- requirements
Module: neuron_layer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed width of inputs, weights and bias.
REQ-002 SHALL have parameter N_IN, default 4: inputs per neuron.
REQ-003 SHALL have parameter N_NEURON, default 3: neurons per layer.
REQ-004 SHALL have parameter ACC_W, default 2*DATA_W+8: signed accumulator width.
REQ-005 SHALL have parameter OUT_W, default DATA_W+8: signed output width.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 start  in  1  begin one layer pass; accepted only in IDLE.
REQ-009 relu_en  in  1  activation select, sampled on accepted start.
REQ-010 x_addr  out  clog2(N_IN)  input-memory read address.
REQ-011 w_addr  out  clog2(N_IN*N_NEURON)  weight-memory read address.
REQ-012 rd_en  out  1  read strobe; x_data and w_data valid exactly 1 cycle later.
REQ-013 x_data, w_data  in  DATA_W each  signed read data.
REQ-014 b_addr  out  clog2(N_NEURON)  bias address; bias_data is combinational from b_addr.
REQ-015 bias_data  in  DATA_W  signed bias.
REQ-016 out_data  out  OUT_W  signed neuron result.
REQ-017 out_idx  out  clog2(N_NEURON)  neuron index of out_data.
REQ-018 out_valid / out_ready  out / in  1 each  valid-ready output handshake.
REQ-019 busy  out  1  high in every state except IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-020 FSM states SHALL be IDLE, MAC, DRAIN, BIAS, ACT, OUT.
REQ-021 IDLE + start: clear accumulator, neu_idx=0, in_idx=0, latch relu_en, go to MAC.
REQ-022 MAC: rd_en=1, x_addr=in_idx, w_addr=neu_idx*N_IN+in_idx, in_idx increments each cycle; after issuing in_idx=N_IN-1, go to DRAIN.
REQ-023 A registered read-valid flag SHALL add sign-extended x_data*w_data to the accumulator in the cycle after each rd_en, including the DRAIN cycle.
REQ-024 BIAS (1 cycle): b_addr=neu_idx; add sign-extended bias_data to the accumulator.
REQ-025 ACT (1 cycle): with relu_en latched high, register max(0,acc) clamped to 2^(OUT_W-1)-1; otherwise register acc saturated to the signed OUT_W range. In the same cycle set out_valid=1 and out_idx=neu_idx.
REQ-026 out_valid SHALL first be high N_IN+3 cycles after MAC entry.
REQ-027 OUT: hold out_data, out_idx and out_valid stable until out_ready=1.
REQ-028 On handshake with neu_idx<N_NEURON-1: drop out_valid, increment neu_idx, clear accumulator and in_idx, go to MAC.
REQ-029 On handshake with neu_idx=N_NEURON-1: drop out_valid, pulse done for 1 cycle, go to IDLE.
REQ-030 start SHALL be ignored while busy=1; start in the done cycle is accepted, with busy high the next cycle.
REQ-031 Accumulation SHALL wrap modulo 2^ACC_W; only the final output is saturated.
REQ-032 rd_en SHALL be 0 outside MAC.

Reset
REQ-033 rst_n=0 at a clock edge: state=IDLE; busy, done, rd_en, out_valid=0; out_data, out_idx, accumulator and all indices=0; any in-progress pass is abandoned.
REQ-034 Reset SHALL take priority over start and out_ready in the same cycle.

Structure
REQ-035 A shared package nn_pkg SHALL hold the FSM state enum and a saturate-to-width function.
REQ-036 The multiply-accumulate SHALL be one sub-module, nn_mac (clear, en, a, b, acc), instantiated once.

Verification
REQ-037 x=[1,2,3,4], w row0=[1,1,1,1], bias0=5, relu_en=1, out_ready=1 -> neuron0 out_data=15, first out_valid at cycle 7 after MAC entry.
REQ-038 Row1 weights=[-1,-1,-1,-1], bias1=0, relu_en=1 -> out_data=0; same with relu_en=0 -> out_data=-10.
REQ-039 out_ready held low 5 cycles at neuron1 -> out_data and out_idx=1 stable; no new reads; done pulses only after the neuron2 handshake.
REQ-040 x=w=127 for all inputs, bias=127, relu_en=1, OUT_W=10 -> out_data=511 (saturated).
REQ-041 start pulsed during MAC of neuron1 -> ignored, sequence unchanged; rst_n low in BIAS -> all outputs 0 next cycle, and the next start restarts at neuron0.
REQ-042 Back-to-back start in the done cycle -> second pass runs, three outputs with out_idx 0,1,2.
